// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for uart_fifo_link.
// Holds the TX/RX state encodings and the frame-bit line levels.
// Optional feature: UART_FIFO_LINK_PARITY_EN adds the PARITY state (even parity).
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_FIFO_LINK_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_FIFO_LINK_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo -- single-clock show-ahead FIFO.
// Ports: i_clk, i_rst_n (async, active-low), i_push/i_data (write),
//        i_pop (read), o_data (head, 0 when empty), o_full, o_empty.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH (power of two).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_fifo_link.sv
// uart_fifo_link -- UART transmitter/receiver with TX and RX FIFOs.
// Ports: Clock, Reset (async, active-low); load/Tx_Data push the TX FIFO;
//        SEND enables new TX frames; READ pops the RX FIFO, Rx_Data is its head;
//        SI serial in (async), SO serial out (registered); loopback feeds SO to RX;
//        tx_full, rx_empty, NINTO, NINTI status; err_clr clears frame_err/overrun.
// Optional feature: define UART_FIFO_LINK_PARITY_EN for an even-parity bit.
module uart_fifo_link
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [DATA_W-1:0] Tx_Data,
  input  logic              SEND,
  input  logic              READ,
  output logic [DATA_W-1:0] Rx_Data,
  input  logic              SI,
  output logic              SO,
  input  logic              loopback,
  output logic              tx_full,
  output logic              rx_empty,
  output logic              NINTO,
  output logic              NINTI,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  // ---------------- FIFOs ----------------
  logic              w_tx_pop, w_tx_empty, w_rx_push, w_rx_full;
  logic [DATA_W-1:0] w_tx_head;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift;

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk(Clock), .i_rst_n(Reset), .i_push(load), .i_data(Tx_Data),
    .i_pop(w_tx_pop), .o_data(w_tx_head), .o_full(tx_full), .o_empty(w_tx_empty)
  );

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk(Clock), .i_rst_n(Reset), .i_push(w_rx_push), .i_data(r_rx_shift),
    .i_pop(READ), .o_data(Rx_Data), .o_full(w_rx_full), .o_empty(rx_empty)
  );

  // ---------------- TX FSM ----------------
  tx_state_t         r_tx_state, w_tx_state;
  logic [CW-1:0]     r_tx_cnt, w_tx_cnt;
  logic [BW-1:0]     r_tx_bit, w_tx_bit;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift;
  logic              r_so, w_so;
  logic              w_tx_bit_end, w_tx_load;
`ifdef UART_FIFO_LINK_PARITY_EN
  logic              r_tx_par, w_tx_par;
`endif

  assign SO    = r_so;
  assign NINTO = ~(w_tx_empty && (r_tx_state == TX_IDLE));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_so       <= STOP_BIT;
`ifdef UART_FIFO_LINK_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_shift <= w_tx_shift;
      r_so       <= w_so;
`ifdef UART_FIFO_LINK_PARITY_EN
      r_tx_par   <= w_tx_par;
`endif
    end
  end

  assign w_tx_bit_end = (r_tx_cnt == BIT_END);
  // A new frame starts from IDLE or straight out of the last STOP cycle (no gap).
  assign w_tx_load = SEND && !w_tx_empty &&
                     ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_bit_end));
  assign w_tx_pop  = w_tx_load;

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt + 1'b1;
    w_tx_bit   = r_tx_bit;
    w_tx_shift = r_tx_shift;
    w_so       = r_so;
`ifdef UART_FIFO_LINK_PARITY_EN
    w_tx_par   = r_tx_par;
`endif
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt = '0;
        w_so     = STOP_BIT;
      end
      TX_START: if (w_tx_bit_end) begin
        w_tx_cnt   = '0;
        w_tx_bit   = '0;
        w_tx_state = TX_DATA;
        w_so       = r_tx_shift[0];
      end
      TX_DATA: if (w_tx_bit_end) begin
        w_tx_cnt = '0;
        if (r_tx_bit == LAST_BIT) begin
`ifdef UART_FIFO_LINK_PARITY_EN
          w_tx_state = TX_PARITY;
          w_so       = r_tx_par;
`else
          w_tx_state = TX_STOP;
          w_so       = STOP_BIT;
`endif
        end else begin
          w_tx_bit   = r_tx_bit + 1'b1;
          w_tx_shift = r_tx_shift >> 1;
          w_so       = r_tx_shift[1];
        end
      end
`ifdef UART_FIFO_LINK_PARITY_EN
      TX_PARITY: if (w_tx_bit_end) begin
        w_tx_cnt   = '0;
        w_tx_state = TX_STOP;
        w_so       = STOP_BIT;
      end
`endif
      TX_STOP: if (w_tx_bit_end) begin
        w_tx_cnt   = '0;
        w_tx_state = TX_IDLE;
        w_so       = STOP_BIT;
      end
      default: w_tx_state = TX_IDLE;
    endcase
    // Frame launch overrides the per-state defaults above.
    if (w_tx_load) begin
      w_tx_state = TX_START;
      w_tx_cnt   = '0;
      w_tx_shift = w_tx_head;
      w_so       = START_BIT;
`ifdef UART_FIFO_LINK_PARITY_EN
      w_tx_par   = ^w_tx_head;
`endif
    end
  end

  // ---------------- RX path ----------------
  rx_state_t     r_rx_state, w_rx_state;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt;
  logic [BW-1:0] r_rx_bit, w_rx_bit;
  logic          r_si_meta, r_si_sync, r_line_prev, w_line;
  logic          w_frame_evt, w_overrun_evt, r_frame_err, r_overrun;
`ifdef UART_FIFO_LINK_PARITY_EN
  logic          r_rx_par_err, w_rx_par_err;
`endif

  assign w_line    = loopback ? r_so : r_si_sync;
  assign NINTI     = rx_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_si_meta    <= 1'b1;
      r_si_sync    <= 1'b1;
      r_line_prev  <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_FIFO_LINK_PARITY_EN
      r_rx_par_err <= 1'b0;
`endif
    end else begin
      r_si_meta    <= SI;
      r_si_sync    <= r_si_meta;
      r_line_prev  <= w_line;
      r_rx_state   <= w_rx_state;
      r_rx_cnt     <= w_rx_cnt;
      r_rx_bit     <= w_rx_bit;
      r_rx_shift   <= w_rx_shift;
`ifdef UART_FIFO_LINK_PARITY_EN
      r_rx_par_err <= w_rx_par_err;
`endif
      // An error event in the same cycle as err_clr wins.
      if (w_frame_evt)   r_frame_err <= 1'b1;
      else if (err_clr)  r_frame_err <= 1'b0;
      if (w_overrun_evt) r_overrun   <= 1'b1;
      else if (err_clr)  r_overrun   <= 1'b0;
    end
  end

  always_comb begin
    w_rx_state    = r_rx_state;
    w_rx_cnt      = r_rx_cnt + 1'b1;
    w_rx_bit      = r_rx_bit;
    w_rx_shift    = r_rx_shift;
    w_rx_push     = 1'b0;
    w_frame_evt   = 1'b0;
    w_overrun_evt = 1'b0;
`ifdef UART_FIFO_LINK_PARITY_EN
    w_rx_par_err  = r_rx_par_err;
`endif
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt = '0;
        if (r_line_prev && !w_line) w_rx_state = RX_START;
      end
      RX_START: if (r_rx_cnt == HALF_END) begin
        w_rx_cnt   = '0;
        w_rx_bit   = '0;
        w_rx_state = w_line ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == BIT_END) begin
        w_rx_cnt   = '0;
        w_rx_shift = {w_line, r_rx_shift[DATA_W-1:1]};
        if (r_rx_bit == LAST_BIT) begin
`ifdef UART_FIFO_LINK_PARITY_EN
          w_rx_state = RX_PARITY;
`else
          w_rx_state = RX_STOP;
`endif
        end else begin
          w_rx_bit = r_rx_bit + 1'b1;
        end
      end
`ifdef UART_FIFO_LINK_PARITY_EN
      RX_PARITY: if (r_rx_cnt == BIT_END) begin
        w_rx_cnt     = '0;
        w_rx_par_err = w_line ^ (^r_rx_shift);
        w_rx_state   = RX_STOP;
      end
`endif
      RX_STOP: if (r_rx_cnt == BIT_END) begin
        w_rx_cnt   = '0;
        w_rx_state = RX_IDLE;
`ifdef UART_FIFO_LINK_PARITY_EN
        if ((w_line == STOP_BIT) && !r_rx_par_err) begin
`else
        if (w_line == STOP_BIT) begin
`endif
          if (w_rx_full) w_overrun_evt = 1'b1;
          else           w_rx_push     = 1'b1;
        end else begin
          w_frame_evt = 1'b1;
        end
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

endmodule
